id_ex_reg: RTL

- ID/EX pipeline register of the pipelined RV32I core; sits directly downstream of the decode controller and register-file read, feeds the EX stage.
- Captures the decoded control bundle, operands and instruction context each cycle; supports stall (hold) and flush (bubble).
- Converts illegal instructions into a clean exception-tagged bubble so EX/MEM/WB never commit side effects for them.

---
 rtl/id_ex_reg_pkg.sv | 54 +++++
 rtl/pipe_field_reg.sv | 26 ++
 rtl/id_ex_reg.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared encodings, opcode constants and the control bundle type for the ID/EX register.
package id_ex_reg_pkg;

    // Next-PC select; NPC_PC4 is the all-zero encoding so bubbles fall through sequentially.
    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JAL  = 2'b10;
    localparam logic [1:0] NPC_JALR = 2'b11;

    localparam logic [2:0] EXT_I  = 3'd0;
    localparam logic [1:0] WB_ALU = 2'd0;

    localparam int unsigned EXC_ILLEGAL_CODE = 2;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [2:0] sext_op;
        logic [1:0] npc_op;
        logic       ram_we;
        logic [1:0] ram_w_op;
        logic [2:0] mem_ext_op;
        logic [3:0] alu_op;
        logic [2:0] alu_f_op;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic       rd1_en;
        logic       rd2_en;
        logic       rf_we;
        logic [1:0] rf_wsel;
        logic       is_load;
        logic       invalid_instruction;
    } ctrl_t;

    // Every supported opcode ends in 2'b11, so a match also implies a 32-bit encoding.
    function automatic logic opcode_legal(input logic [6:0] opc);
        logic legal;
        case (opc)
            OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_JALR, OPC_STORE,
            OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Pipeline field register: async reset value, stall hold, flush to bubble value.
module pipe_field_reg #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0,
    parameter logic [W-1:0]  BUB_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Flush wins over stall so a redirect always kills the stage contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (flush) begin
            q <= BUB_VAL;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode output, turns illegal instructions into
// exception-tagged bubbles with all architectural side effects suppressed.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned EXC_ILLEGAL = EXC_ILLEGAL_CODE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [31:0]     id_inst,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_ext,
    input  logic [2:0]      id_sext_op,
    input  logic [1:0]      id_npc_op,
    input  logic            id_ram_we,
    input  logic [1:0]      id_ram_w_op,
    input  logic [2:0]      id_mem_ext_op,
    input  logic [3:0]      id_alu_op,
    input  logic [2:0]      id_alu_f_op,
    input  logic            id_alu_a_sel,
    input  logic            id_alu_b_sel,
    input  logic            id_rd1_en,
    input  logic            id_rd2_en,
    input  logic            id_rf_we,
    input  logic [1:0]      id_rf_wsel,
    input  logic            id_is_load,
    input  logic            id_invalid_instruction,
    output logic            ex_valid,
    output logic [31:0]     ex_inst,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_pc4,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_ext,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [2:0]      ex_sext_op,
    output logic [1:0]      ex_npc_op,
    output logic            ex_ram_we,
    output logic [1:0]      ex_ram_w_op,
    output logic [2:0]      ex_mem_ext_op,
    output logic [3:0]      ex_alu_op,
    output logic [2:0]      ex_alu_f_op,
    output logic            ex_alu_a_sel,
    output logic            ex_alu_b_sel,
    output logic            ex_rd1_en,
    output logic            ex_rd2_en,
    output logic            ex_rf_we,
    output logic [1:0]      ex_rf_wsel,
    output logic            ex_is_load,
    output logic            ex_invalid_instruction,
    output logic            ex_exc_valid,
    output logic [3:0]      ex_exc_cause,
    output logic [31:0]     ex_exc_tval
);

    localparam int unsigned CTX_W  = 1 + 32 + 2 * XLEN;
    localparam int unsigned DATA_W = 3 * XLEN;
    localparam int unsigned REGS_W = 15;
    localparam int unsigned CTRL_W = $bits(ctrl_t);
    localparam int unsigned EXC_W  = 1 + 4 + 32;

    logic              illegal;
    logic [CTX_W-1:0]  ctx_d,  ctx_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic [REGS_W-1:0] regs_d, regs_q;
    ctrl_t             ctrl_d, ctrl_q;
    logic [EXC_W-1:0]  exc_d,  exc_q;

    // Build the load image; an empty ID slot loads the same all-zero bubble as a flush.
    always_comb begin
        illegal = id_invalid_instruction | ~opcode_legal(id_inst[6:0]);

        ctrl_d = '{
            sext_op:             id_sext_op,
            npc_op:              id_npc_op,
            ram_we:              id_ram_we,
            ram_w_op:            id_ram_w_op,
            mem_ext_op:          id_mem_ext_op,
            alu_op:              id_alu_op,
            alu_f_op:            id_alu_f_op,
            alu_a_sel:           id_alu_a_sel,
            alu_b_sel:           id_alu_b_sel,
            rd1_en:              id_rd1_en,
            rd2_en:              id_rd2_en,
            rf_we:               id_rf_we,
            rf_wsel:             id_rf_wsel,
            is_load:             id_is_load,
            invalid_instruction: id_invalid_instruction
        };
        if (illegal) begin
            ctrl_d.rf_we   = 1'b0;
            ctrl_d.ram_we  = 1'b0;
            ctrl_d.is_load = 1'b0;
            ctrl_d.npc_op  = NPC_PC4;
        end

        ctx_d  = {1'b1, id_inst, id_pc, id_pc + XLEN'(4)};
        data_d = {id_rd1, id_rd2, id_ext};
        // A non-writing instruction carries rd=0 so forwarding can never match it.
        regs_d = {(ctrl_d.rf_we ? id_inst[11:7] : 5'd0), id_inst[19:15], id_inst[24:20]};
        exc_d  = illegal ? {1'b1, 4'(EXC_ILLEGAL), id_inst} : '0;

        if (!id_valid) begin
            ctrl_d = '0;
            ctx_d  = '0;
            data_d = '0;
            regs_d = '0;
            exc_d  = '0;
        end
    end

    // Reset and bubble encodings are all-zero (NPC_PC4, EXT_I, WB_ALU included).
    pipe_field_reg #(.W(CTX_W), .RST_VAL('0), .BUB_VAL('0)) u_ctx (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .d(ctx_d), .q(ctx_q)
    );
    pipe_field_reg #(.W(DATA_W), .RST_VAL('0), .BUB_VAL('0)) u_data (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .d(data_d), .q(data_q)
    );
    pipe_field_reg #(.W(REGS_W), .RST_VAL('0), .BUB_VAL('0)) u_regs (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .d(regs_d), .q(regs_q)
    );
    pipe_field_reg #(.W(CTRL_W), .RST_VAL('0), .BUB_VAL('0)) u_ctrl (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .d(ctrl_d), .q(ctrl_q)
    );
    pipe_field_reg #(.W(EXC_W), .RST_VAL('0), .BUB_VAL('0)) u_exc (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .d(exc_d), .q(exc_q)
    );

    assign {ex_valid, ex_inst, ex_pc, ex_pc4}        = ctx_q;
    assign {ex_rd1, ex_rd2, ex_ext}                  = data_q;
    assign {ex_rd, ex_rs1, ex_rs2}                   = regs_q;
    assign {ex_exc_valid, ex_exc_cause, ex_exc_tval} = exc_q;

    assign ex_sext_op             = ctrl_q.sext_op;
    assign ex_npc_op              = ctrl_q.npc_op;
    assign ex_ram_we              = ctrl_q.ram_we;
    assign ex_ram_w_op            = ctrl_q.ram_w_op;
    assign ex_mem_ext_op          = ctrl_q.mem_ext_op;
    assign ex_alu_op              = ctrl_q.alu_op;
    assign ex_alu_f_op            = ctrl_q.alu_f_op;
    assign ex_alu_a_sel           = ctrl_q.alu_a_sel;
    assign ex_alu_b_sel           = ctrl_q.alu_b_sel;
    assign ex_rd1_en              = ctrl_q.rd1_en;
    assign ex_rd2_en              = ctrl_q.rd2_en;
    assign ex_rf_we               = ctrl_q.rf_we;
    assign ex_rf_wsel             = ctrl_q.rf_wsel;
    assign ex_is_load             = ctrl_q.is_load;
    assign ex_invalid_instruction = ctrl_q.invalid_instruction;

endmodule
